// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider: restoring division on magnitudes, signs applied afterwards.
// Define SEQ_DIV_DIV0_EN to add the div0 divide-by-zero flag output.
module seq_signed_div #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
`ifdef SEQ_DIV_DIV0_EN
  ,
  output logic         div0
`endif
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q, quo_q, dvs_q, dvd_q;
  logic [W-1:0]  quotient_q, remainder_q;
  logic          neg_quo_q, neg_rem_q, in_ready_q, out_valid_q;
  logic [W:0]    shift_d, diff_d;
  logic [W-1:0]  rem_d, quo_d;
`ifdef SEQ_DIV_DIV0_EN
  logic          div0_q;
`endif

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  // One restoring step: the borrow bit of the W+1-bit difference decides the quotient bit.
  always_comb begin
    shift_d = {rem_q, quo_q[W-1]};
    diff_d  = shift_d - {1'b0, dvs_q};
    rem_d   = shift_d[W-1:0];
    quo_d   = {quo_q[W-2:0], 1'b0};
    if (!diff_d[W]) begin
      rem_d = diff_d[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_DIV_DIV0_EN
      div0_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            cnt_q      <= CW'(W);
            rem_q      <= '0;
            quo_q      <= mag(dividend);
            dvs_q      <= mag(divisor);
            dvd_q      <= dividend;
            neg_quo_q  <= dividend[W-1] ^ divisor[W-1];
            neg_rem_q  <= dividend[W-1];
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          if (dvs_q == '0) begin
            quotient_q  <= '1;
            remainder_q <= dvd_q;
          end else begin
            quotient_q  <= neg_quo_q ? -quo_q : quo_q;
            remainder_q <= neg_rem_q ? -rem_q : rem_q;
          end
`ifdef SEQ_DIV_DIV0_EN
          div0_q      <= (dvs_q == '0);
`endif
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
`ifdef SEQ_DIV_DIV0_EN
            div0_q      <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef SEQ_DIV_DIV0_EN
  assign div0      = div0_q;
`endif

endmodule

// File: tb/tb_seq_signed_div.sv
// Directed scoreboard bench for seq_signed_div (W=4); div0 checked when SEQ_DIV_DIV0_EN is defined.
module tb_seq_signed_div;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] quotient, remainder;
  logic         div0_obs;

`ifdef SEQ_DIV_DIV0_EN
  logic div0;
  assign div0_obs = div0;
`else
  assign div0_obs = 1'b0;
`endif

  seq_signed_div #(.W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQ_DIV_DIV0_EN
    ,
    .div0      (div0)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d0;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    int ia, ib, iq, ir;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) begin
      m.q  = '1;
      m.r  = a;
      m.d0 = 1'b1;
    end else begin
      iq   = ia / ib;
      ir   = ia % ib;
      m.q  = iq[W-1:0];
      m.r  = ir[W-1:0];
      m.d0 = 1'b0;
    end
    return m;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  // Called #1 after the accepting edge; hold>0 keeps out_ready low that many cycles in DONE.
  task automatic collect(input int hold);
    int   lat;
    bit   seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      check("in_ready_busy", in_ready, 0);
    end
    check("out_valid_seen", seen, 1);
    check("latency", lat, W + 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
`ifdef SEQ_DIV_DIV0_EN
    check("div0", div0_obs, e.d0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      check("hold_q", quotient, e.q);
      check("hold_r", remainder, e.r);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    if (hold > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_div0", div0_obs, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_div0", div0_obs, 0);
    reset_n = 1'b1;

    issue(4'd7, 4'd2);   collect(0);
    issue(-4'sd7, 4'd2); collect(0);
    issue(4'd7, -4'sd2); collect(0);
    issue(-4'sd7, -4'sd2); collect(0);
    issue(-4'sd8, -4'sd1); collect(0);
    issue(-4'sd8, 4'd1); collect(0);
    issue(4'd3, 4'd5);   collect(0);
    issue(4'd5, 4'd0);   collect(0);

    out_ready = 1'b0;
    issue(-4'sd6, 4'd4); collect(6);

    issue(4'd7, 4'd3);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_div0", div0_obs, 0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    issue(4'd6, 4'd3);   collect(0);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
